// File: rtl/packet_disassembler.sv
// HDMI data island receiver: rebuilds header/subpackets and checks the BCH ECC bytes.
// Optional: define AUDIO_FRAME_COUNTER_EN to count IEC 60958 frames on audio sample packets.
module packet_disassembler #(
   parameter int DROP_BAD_PACKETS = 0
) (
   input  logic        clk_pixel,
   input  logic        reset,
   input  logic        data_island_period,
   input  logic [8:0]  packet_data,
   output logic        packet_valid,
   output logic [23:0] header,
   output logic [55:0] sub [3:0],
   output logic [7:0]  packet_type,
   output logic        header_ecc_error,
   output logic [3:0]  sub_ecc_error,
   output logic [7:0]  frame_counter
);

   logic [4:0]        r_cnt;
   logic [7:0]        r_ecc_h;
   logic [7:0]        r_par_h;
   logic [23:0]       r_hdr_sr;
   logic [23:0]       r_header;
   logic [3:0][7:0]   r_ecc_s;
   logic [3:0][7:0]   r_par_s;
   logic [3:0][55:0]  r_sub_sr;
   logic [3:0][55:0]  r_sub;
   logic              r_valid;
   logic              r_herr;
   logic [3:0]        r_serr;

   logic              w_last;
   logic [7:0]        w_par_h;
   logic [3:0][7:0]   w_par_s;
   logic              w_herr;
   logic [3:0]        w_serr;
   logic              w_bad;
   logic              w_load;

   function automatic logic [7:0] f_ecc(input logic [7:0] e, input logic b);
      f_ecc = (e[0] ^ b) ? ((e >> 1) ^ 8'h83) : (e >> 1);
   endfunction

   // Beat-31 parity bits are used straight off the input.
   always_comb begin
      w_last  = data_island_period && (r_cnt == 5'd31);
      w_par_h = {packet_data[0], r_par_h[7:1]};
      w_herr  = (w_par_h != r_ecc_h);
      w_par_s = '0;
      w_serr  = '0;
      for (int i = 0; i < 4; i++) begin
         w_par_s[i] = {packet_data[5+i], packet_data[1+i], r_par_s[i][7:2]};
         w_serr[i]  = (w_par_s[i] != r_ecc_s[i]);
      end
      w_bad  = w_herr | (|w_serr);
      w_load = w_last && ((DROP_BAD_PACKETS == 0) || !w_bad);
   end

   always_ff @(posedge clk_pixel) begin
      if (reset) begin
         r_cnt    <= '0;
         r_ecc_h  <= '0;
         r_par_h  <= '0;
         r_hdr_sr <= '0;
         r_header <= '0;
         r_ecc_s  <= '0;
         r_par_s  <= '0;
         r_sub_sr <= '0;
         r_sub    <= '0;
         r_valid  <= 1'b0;
         r_herr   <= 1'b0;
         r_serr   <= '0;
      end else begin
         r_valid <= w_load;
         if (!data_island_period) begin
            r_cnt   <= '0;
            r_ecc_h <= '0;
            r_par_h <= '0;
            r_ecc_s <= '0;
            r_par_s <= '0;
         end else begin
            r_cnt <= r_cnt + 5'd1;
            if (r_cnt < 5'd24) begin
               r_ecc_h  <= f_ecc(r_ecc_h, packet_data[0]);
               r_hdr_sr <= {packet_data[0], r_hdr_sr[23:1]};
            end else begin
               r_par_h <= {packet_data[0], r_par_h[7:1]};
            end
            for (int i = 0; i < 4; i++) begin
               if (r_cnt < 5'd28) begin
                  r_ecc_s[i]  <= f_ecc(f_ecc(r_ecc_s[i], packet_data[1+i]),
                                       packet_data[5+i]);
                  r_sub_sr[i] <= {packet_data[5+i], packet_data[1+i],
                                  r_sub_sr[i][55:2]};
               end else begin
                  r_par_s[i] <= {packet_data[5+i], packet_data[1+i],
                                 r_par_s[i][7:2]};
               end
            end
            if (w_last) begin
               r_ecc_h <= '0;
               r_par_h <= '0;
               r_ecc_s <= '0;
               r_par_s <= '0;
               r_herr  <= w_herr;
               r_serr  <= w_serr;
               if (w_load) begin
                  r_header <= r_hdr_sr;
                  r_sub    <= r_sub_sr;
               end
            end
         end
      end
   end

   for (genvar g = 0; g < 4; g++) begin : g_sub
      assign sub[g] = r_sub[g];
   end

   assign packet_valid     = r_valid;
   assign header           = r_header;
   assign packet_type      = r_header[7:0];
   assign header_ecc_error = r_herr;
   assign sub_ecc_error    = r_serr;

`ifdef AUDIO_FRAME_COUNTER_EN
   logic [7:0] r_frame;

   // Only clean audio sample packets advance the 192-frame block index.
   always_ff @(posedge clk_pixel) begin
      if (reset) begin
         r_frame <= '0;
      end else if (w_last && !w_bad && (r_hdr_sr[7:0] == 8'h02)) begin
         r_frame <= (r_frame == 8'd191) ? 8'd0 : r_frame + 8'd1;
      end
   end

   assign frame_counter = r_frame;
`else
   assign frame_counter = 8'd0;
`endif

endmodule

// File: tb/tb_packet_disassembler.sv
// Directed bench for packet_disassembler: keep-bad and drop-bad instances share one stimulus.
// Expected parity comes from a bench-side ECC model of the transmit serializer.
module tb_packet_disassembler;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        dip;
   logic [8:0]  pd;
   logic        v0, v1;
   logic [23:0] h0, h1;
   logic [55:0] s0 [3:0];
   logic [55:0] s1 [3:0];
   logic [7:0]  t0, t1;
   logic        he0, he1;
   logic [3:0]  se0, se1;
   logic [7:0]  fc0, fc1;

   packet_disassembler #(.DROP_BAD_PACKETS(0)) u_dut0 (
      .clk_pixel(clk), .reset(rst), .data_island_period(dip),
      .packet_data(pd), .packet_valid(v0), .header(h0), .sub(s0),
      .packet_type(t0), .header_ecc_error(he0), .sub_ecc_error(se0),
      .frame_counter(fc0)
   );

   packet_disassembler #(.DROP_BAD_PACKETS(1)) u_dut1 (
      .clk_pixel(clk), .reset(rst), .data_island_period(dip),
      .packet_data(pd), .packet_valid(v1), .header(h1), .sub(s1),
      .packet_type(t1), .header_ecc_error(he1), .sub_ecc_error(se1),
      .frame_counter(fc1)
   );

   int checks = 0;
   int errors = 0;
   int ns0 = 0;
   int ns1 = 0;
   int xs0 = 0;
   int xs1 = 0;

   always @(negedge clk) begin
      if (v0) ns0++;
      if (v1) ns1++;
   end

   typedef struct {
      logic [23:0]      hdr;
      logic [3:0][55:0] sb;
      int               fblk;
      int               fbit;
      logic             herr;
      logic [3:0]       serr;
   } vec_t;

   localparam logic [3:0][55:0] SB_A = {
      56'h00FF00FF00FF00, 56'h5A5AA5A5C3C33C,
      56'hFEDCBA98765432, 56'h0123456789ABCD};
   localparam logic [3:0][55:0] SB_B = {
      56'h11223344556677, 56'h8899AABBCCDDEE,
      56'h0F1E2D3C4B5A69, 56'h7766554433221F};

   logic [31:0]      b4;
   logic [3:0][63:0] bs;
   logic [23:0]      e0h, e1h;
   logic [3:0][55:0] e0s, e1s;
   int               efc = 0;
   vec_t             tv [9];

   function automatic vec_t mk(input logic [23:0] h, input logic [3:0][55:0] sb,
                               input int fb, input int fi,
                               input logic he, input logic [3:0] se);
      vec_t v;
      v.hdr = h; v.sb = sb; v.fblk = fb; v.fbit = fi;
      v.herr = he; v.serr = se;
      return v;
   endfunction

   function automatic logic [7:0] ecc_of(input logic [63:0] bits, input int n);
      logic [7:0] e;
      e = 8'h00;
      for (int j = 0; j < n; j++)
         e = (e[0] ^ bits[j]) ? ((e >> 1) ^ 8'h83) : (e >> 1);
      return e;
   endfunction

   task automatic build(input logic [23:0] hdr, input logic [3:0][55:0] sb,
                        input int fblk, input int fbit);
      b4 = {ecc_of({40'h0, hdr}, 24), hdr};
      for (int i = 0; i < 4; i++)
         bs[i] = {ecc_of({8'h0, sb[i]}, 56), sb[i]};
      if (fblk == 4) b4[fbit] = ~b4[fbit];
      else if (fblk >= 0) bs[fblk][fbit] = ~bs[fblk][fbit];
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input int n);
      for (int k = 0; k < n; k++) begin
         dip   = 1'b1;
         pd[0] = b4[k];
         for (int i = 0; i < 4; i++) begin
            pd[1+i] = bs[i][2*k];
            pd[5+i] = bs[i][2*k+1];
         end
         tick();
      end
   endtask

   task automatic idle(input int n);
      dip = 1'b0;
      pd  = '0;
      repeat (n) tick();
   endtask

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %h want %h", nm, act, exp);
      end
   endtask

   task automatic check_outputs();
      chk("hdr0", h0, e0h);
      chk("type0", t0, e0h[7:0]);
      chk("hdr1", h1, e1h);
      chk("type1", t1, e1h[7:0]);
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("sub0_%0d", i), s0[i], e0s[i]);
         chk($sformatf("sub1_%0d", i), s1[i], e1s[i]);
      end
      chk("fc0", fc0, efc);
      chk("fc1", fc1, efc);
   endtask

   // Call one cycle after beat 31 was sampled.
   task automatic check_pkt(input logic herr, input logic [3:0] serr);
      logic bad;
      bad = herr | (|serr);
      chk("valid0", v0, 1'b1);
      chk("valid1", v1, !bad);
      xs0++;
      if (!bad) xs1++;
      e0h = b4[23:0];
      for (int i = 0; i < 4; i++) e0s[i] = bs[i][55:0];
      if (!bad) begin
         e1h = e0h;
         e1s = e0s;
`ifdef AUDIO_FRAME_COUNTER_EN
         if (b4[7:0] == 8'h02) efc = (efc == 191) ? 0 : efc + 1;
`endif
      end
      chk("herr0", he0, herr);
      chk("serr0", se0, serr);
      chk("herr1", he1, herr);
      chk("serr1", se1, serr);
      check_outputs();
   endtask

   task automatic check_counts();
      chk("strobes0", ns0, xs0);
      chk("strobes1", ns1, xs1);
   endtask

   initial begin
      tv[0] = mk(24'h000000, '0,   -1,  0, 1'b0, 4'b0000);
      tv[1] = mk(24'h0A0184, SB_A, -1,  0, 1'b0, 4'b0000);
      tv[2] = mk(24'h0A0184, SB_A,  2, 10, 1'b0, 4'b0100);
      tv[3] = mk(24'h0A0184, SB_B,  4,  5, 1'b1, 4'b0000);
      tv[4] = mk(24'h0F0002, SB_B, -1,  0, 1'b0, 4'b0000);
      tv[5] = mk(24'h0F0002, SB_A,  0, 60, 1'b0, 4'b0001);
      tv[6] = mk(24'h123456, SB_B,  3, 63, 1'b0, 4'b1000);
      tv[7] = mk(24'h0A0184, SB_B,  4, 31, 1'b1, 4'b0000);
      tv[8] = mk(24'h0F0002, SB_A,  1,  0, 1'b0, 4'b0010);

      rst = 1'b1; dip = 1'b0; pd = '0;
      e0h = '0; e1h = '0; e0s = '0; e1s = '0;
      repeat (3) tick();
      rst = 1'b0;
      tick();
      chk("rst_valid0", v0, 1'b0);
      chk("rst_valid1", v1, 1'b0);
      chk("rst_herr", he0, 1'b0);
      chk("rst_serr", se0, 4'b0000);
      check_outputs();

      for (int n = 0; n < 9; n++) begin
         build(tv[n].hdr, tv[n].sb, tv[n].fblk, tv[n].fbit);
         send(32);
         check_pkt(tv[n].herr, tv[n].serr);
         idle(1);
         chk("valid_drop", v0, 1'b0);
         check_counts();
      end

      // Two packets back to back in one island.
      build(tv[1].hdr, tv[1].sb, -1, 0);
      send(32);
      check_pkt(1'b0, 4'b0000);
      build(tv[4].hdr, tv[4].sb, -1, 0);
      send(32);
      check_pkt(1'b0, 4'b0000);
      idle(1);
      check_counts();

      // Truncated island, then a clean packet to prove state was flushed.
      build(24'h654321, SB_B, -1, 0);
      send(20);
      idle(3);
      check_counts();
      check_outputs();
      build(24'h00AA55, SB_A, -1, 0);
      send(32);
      check_pkt(1'b0, 4'b0000);
      idle(1);
      check_counts();

      // Reset in the middle of a packet.
      build(tv[1].hdr, tv[1].sb, -1, 0);
      send(15);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      idle(1);
      e0h = '0; e1h = '0; e0s = '0; e1s = '0; efc = 0;
      check_counts();
      chk("mrst_herr", he0, 1'b0);
      chk("mrst_serr", se0, 4'b0000);
      check_outputs();
      build(tv[4].hdr, tv[4].sb, -1, 0);
      send(32);
      check_pkt(1'b0, 4'b0000);
      idle(1);
      check_counts();

`ifdef AUDIO_FRAME_COUNTER_EN
      rst = 1'b1;
      tick();
      rst = 1'b0;
      idle(1);
      e0h = '0; e1h = '0; e0s = '0; e1s = '0; efc = 0;
      build(24'h0F0002, SB_B, -1, 0);
      for (int p = 1; p <= 193; p++) begin
         send(32);
         check_pkt(1'b0, 4'b0000);
         if (p == 191) chk("fc_191", fc0, 8'd191);
         if (p == 192) chk("fc_wrap", fc0, 8'd0);
         if (p == 193) chk("fc_after", fc0, 8'd1);
      end
      idle(1);
      check_counts();
`else
      chk("fc_tied0", fc0, 8'd0);
      chk("fc_tied1", fc1, 8'd0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
